spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
Synthesizable SPI NOR-flash responder: the slave end of the flash interface that the dma block drives as master on flashClk/flashCs/flashMosi/flashMiso. It serves READ (0x03) from an internal byte memory. Used as an on-chip flash stand-in for simulation and for boards without external flash. All SPI inputs are oversampled in the system clock domain, so no second clock is needed.

Parameters:
MEM_ADDR_BITS, 12, log2 of memory size in bytes (default 4096 B); the low MEM_ADDR_BITS of the 24-bit SPI address are used.
INIT_FILE, "", hex file loaded with $readmemh at elaboration; empty means the memory is left uninitialised.

Ports:
clk  input  1  system clock; the only clock.
reset  input  1  synchronous, active-high reset.
flashClk  input  1  SPI SCK from the master; mode 0 (CPOL=0, CPHA=0).
flashCs  input  1  SPI chip select, active low.
flashMosi  input  1  master-to-slave data, MSB first.
flashMiso  output  1  slave-to-master data, MSB first.
load_we  input  1  backdoor byte write strobe.
load_addr  input  MEM_ADDR_BITS  backdoor write address.
load_data  input  8  backdoor write data.
busy  output  1  high while flashCs is low (synchronised).
last_cmd  output  8  most recent complete command byte.

Behaviour:
- Reset values: flashMiso=0, busy=0, last_cmd=0x00, state=IDLE, bit counter=0. Reset has priority over every other event, including an in-progress transfer. Memory contents are not cleared by reset.
- Synchronisers: flashClk, flashCs and flashMosi each pass through 2 flops. SCK rise and fall edges are detected from the synchronised value against a third delayed flop.
- Timing limit: each SCK high phase and low phase must last at least 4 clk. Faster SCK is unsupported.
- CS handling: a synchronised CS high forces state=IDLE and flashMiso=0 within 1 clk, whatever the current state. A CS falling edge enters CMD with the bit counter cleared.
- State CMD: shift MOSI on each SCK rise. After the 8th bit, latch last_cmd.
  - 0x03 goes to ADDR.
  - Any other command goes to IGNORE.
- State ADDR: shift 24 bits on SCK rises. After the 24th bit, latch addr[MEM_ADDR_BITS-1:0] and issue the memory read. The read is registered, so data is valid 1 clk later, which is before the next SCK fall. Then go to DATA.
- State DATA:
  - On each SCK fall, drive the next bit onto flashMiso, starting with bit 7.
  - After bit 0 has been sampled (8th SCK rise of the byte), increment the address modulo 2^MEM_ADDR_BITS (wraps from the top to 0) and prefetch the next byte.
  - DATA continues indefinitely until CS goes high.
- State IGNORE: flashMiso held 0 and all SCK edges ignored until CS goes high.
- Backdoor port: load_we writes load_data at load_addr on the clk edge, in any state. If it coincides with a prefetch of the same address, the prefetch returns the old byte and the write still completes.
- busy = synchronised !flashCs; asserted 2 clk after CS falls.
- A partial byte or partial address at CS rise is discarded. There are no side effects apart from last_cmd, which updates only on a complete command byte.

Optional Feature:
FAST_READ_EN
- Defined: command 0x0B is also accepted. The flow is ADDR (24 bits), then DUMMY (8 SCK rises ignored, flashMiso=0), then DATA, which behaves identically to 0x03. The memory prefetch is issued at the end of ADDR.
- Undefined: 0x0B is treated like any unknown command and goes to IGNORE.

Test Plan:
- Preload 0x010..0x013 = A5,3C,FF,00 via the backdoor. Run SPI READ 0x03 at address 0x000010 with SCK = clk/8 for 32 data clocks. Required: MISO bytes A5,3C,FF,00 and last_cmd=0x03.
- Preload 0xFFF=11 and 0x000=22. Run READ at address 0x000FFF for 2 bytes. Required: 11 then 22 (wrap). Also read at 0x123FFF and require 11, showing the upper address bits are ignored.
- Send command 0x9F and clock 24 more bits. Required: MISO=0 throughout, last_cmd=0x9F. A following READ at 0x000010 still returns A5.
- Raise CS after 12 address bits, then start a new READ at 0x000011. Required: 3C is returned and no stale address bits are used.
- Assert reset for 1 clk in the middle of the DATA phase. Required: next clk flashMiso=0, busy=0, last_cmd=0x00. After CS toggles high then low, a new READ works.
- With FAST_READ_EN: 0x0B at 0x000010 plus 8 dummy clocks returns A5,3C. Without it: MISO=0 throughout and last_cmd=0x0B.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI NOR-flash responder serving READ (0x03) from an internal byte memory; all SPI pins are
// oversampled on clk. Define FAST_READ_EN to also accept FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_responder #(
  parameter int unsigned MEM_ADDR_BITS = 12,
  parameter string       INIT_FILE     = ""
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flashClk,
  input  logic                     flashCs,
  input  logic                     flashMosi,
  output logic                     flashMiso,
  input  logic                     load_we,
  input  logic [MEM_ADDR_BITS-1:0] load_addr,
  input  logic [7:0]               load_data,
  output logic                     busy,
  output logic [7:0]               last_cmd
);

  localparam int unsigned MEM_DEPTH = 1 << MEM_ADDR_BITS;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned SHIFT_W   = 23;
  localparam logic [7:0]  CMD_READ  = 8'h03;
`ifdef FAST_READ_EN
  localparam logic [7:0]  CMD_FAST_READ = 8'h0B;
`endif

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

  logic sck_s1, sck_s2, sck_d;
  logic cs_s1, cs_s2, cs_d;
  logic mosi_s1, mosi_s2;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SHIFT_W-1:0]       shift_q, shift_d;
  logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic                     fast_q, fast_d;
  logic                     miso_q, miso_d;
  logic                     busy_q;
  logic [7:0]               last_cmd_q, last_cmd_d;

  logic [7:0]               mem [MEM_DEPTH];
  logic [7:0]               mem_q;

  logic                     sck_rise, sck_fall, cs_fall;
  logic                     rd_en_c;
  logic [MEM_ADDR_BITS-1:0] rd_addr_c;
  logic [MEM_ADDR_BITS-1:0] addr_next_c;
  logic [7:0]               cmd_c;
  logic [23:0]              word_c;
  logic                     fast_ok_c;

  // Synchronisers are not reset so that a CS held low across reset is not seen as a new falling edge.
  always_ff @(posedge clk) begin
    sck_s1  <= flashClk;
    sck_s2  <= sck_s1;
    sck_d   <= sck_s2;
    cs_s1   <= flashCs;
    cs_s2   <= cs_s1;
    cs_d    <= cs_s2;
    mosi_s1 <= flashMosi;
    mosi_s2 <= mosi_s1;
  end

  assign sck_rise = sck_s2 & ~sck_d;
  assign sck_fall = ~sck_s2 & sck_d;
  assign cs_fall  = cs_d & ~cs_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      fast_q     <= 1'b0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
      last_cmd_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      fast_q     <= fast_d;
      miso_q     <= miso_d;
      busy_q     <= ~cs_s1;
      last_cmd_q <= last_cmd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    fast_d      = fast_q;
    miso_d      = miso_q;
    last_cmd_d  = last_cmd_q;
    rd_en_c     = 1'b0;
    addr_next_c = addr_q + MEM_ADDR_BITS'(1);
    rd_addr_c   = addr_q;
    cmd_c       = {shift_q[6:0], mosi_s2};
    word_c      = {shift_q, mosi_s2};
`ifdef FAST_READ_EN
    fast_ok_c   = (cmd_c == CMD_FAST_READ);
`else
    fast_ok_c   = 1'b0;
`endif

    if (cs_s2) begin
      state_d = IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else if (cs_fall) begin
      state_d = CMD;
      cnt_d   = '0;
      fast_d  = 1'b0;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        CMD: begin
          miso_d = 1'b0;
          if (sck_rise) begin
            shift_d = {shift_q[SHIFT_W-2:0], mosi_s2};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              last_cmd_d = cmd_c;
              cnt_d      = '0;
              if (cmd_c == CMD_READ) begin
                state_d = ADDR;
              end else if (fast_ok_c) begin
                state_d = ADDR;
                fast_d  = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        ADDR: begin
          miso_d = 1'b0;
          if (sck_rise) begin
            shift_d = {shift_q[SHIFT_W-2:0], mosi_s2};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(23)) begin
              addr_d    = MEM_ADDR_BITS'(word_c);
              rd_en_c   = 1'b1;
              rd_addr_c = MEM_ADDR_BITS'(word_c);
              cnt_d     = '0;
              state_d   = fast_q ? DUMMY : DATA;
            end
          end
        end
        DUMMY: begin
          miso_d = 1'b0;
          if (sck_rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              cnt_d   = '0;
              state_d = DATA;
            end
          end
        end
        DATA: begin
          // Bit index within the byte is 7 - cnt, i.e. the 3-bit complement.
          if (sck_fall) miso_d = mem_q[~cnt_q[2:0]];
          if (sck_rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              cnt_d     = '0;
              addr_d    = addr_next_c;
              rd_en_c   = 1'b1;
              rd_addr_c = addr_next_c;
            end
          end
        end
        IGNORE:  miso_d = 1'b0;
        IDLE:    miso_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  // Read-before-write: a prefetch colliding with a backdoor write returns the old byte.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
    if (rd_en_c) mem_q <= mem[rd_addr_c];
  end

  assign flashMiso = miso_q;
  assign busy      = busy_q;
  assign last_cmd  = last_cmd_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: SPI master at clk/8, backdoor preload, byte model.
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sck, cs, mosi, miso;
  logic        load_we;
  logic [11:0] load_addr;
  logic [7:0]  load_data;
  logic        busy;
  logic [7:0]  last_cmd;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  model_mem [4096];
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  spi_flash_responder dut (
    .clk       (clk),
    .reset     (reset),
    .flashClk  (sck),
    .flashCs   (cs),
    .flashMosi (mosi),
    .flashMiso (miso),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy),
    .last_cmd  (last_cmd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bd_write(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_we = 1'b0;
    model_mem[a] = d;
  endtask

  // Mode 0 master: MOSI set while SCK low, MISO sampled just before the rising edge.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[3'(7 - i)];
      repeat (4) @(negedge clk);
      rx = {rx[6:0], miso};
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic cs_begin();
    @(negedge clk);
    cs = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_high", busy, 1);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    check("busy_low", busy, 0);
  endtask

  task automatic send_cmd_addr(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] rx;
    spi_xfer(cmd, 8, rx);
    check("cmd_miso", rx, 0);
    for (int b = 2; b >= 0; b--) begin
      spi_xfer(addr[b*8 +: 8], 8, rx);
      check("addr_miso", rx, 0);
    end
  endtask

  task automatic pop_check(input string tag, input logic [7:0] got);
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      check(tag, got, exp_q.pop_front());
    end
  endtask

  task automatic read_bytes(input logic [23:0] addr, input int n);
    logic [7:0] rx;
    cs_begin();
    send_cmd_addr(8'h03, addr);
    for (int i = 0; i < n; i++) exp_q.push_back(model_mem[12'(addr + 24'(i))]);
    for (int i = 0; i < n; i++) begin
      spi_xfer(8'h00, 8, rx);
      pop_check("read_data", rx);
    end
    cs_end();
    check("read_last_cmd", last_cmd, 8'h03);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] rx;
    reset = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_miso", miso, 0);
    check("rst_busy", busy, 0);
    check("rst_last_cmd", last_cmd, 8'h00);

    bd_write(12'h010, 8'hA5);
    bd_write(12'h011, 8'h3C);
    bd_write(12'h012, 8'hFF);
    bd_write(12'h013, 8'h00);
    bd_write(12'hFFF, 8'h11);
    bd_write(12'h000, 8'h22);

    read_bytes(24'h000010, 4);
    read_bytes(24'h000FFF, 2);
    read_bytes(24'h123FFF, 1);

    // Unknown command: MISO stays low, last_cmd still records it.
    cs_begin();
    spi_xfer(8'h9F, 8, rx);
    check("ign_cmd_miso", rx, 0);
    for (int i = 0; i < 3; i++) begin
      spi_xfer(8'h5A, 8, rx);
      check("ign_miso", rx, 0);
    end
    cs_end();
    check("ign_last_cmd", last_cmd, 8'h9F);
    read_bytes(24'h000010, 1);

    // Abort after 12 address bits, then a clean read.
    cs_begin();
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'hAB, 8, rx);
    spi_xfer(8'hC0, 4, rx);
    cs_end();
    check("partial_last_cmd", last_cmd, 8'h03);
    read_bytes(24'h000011, 1);

    // Reset in the middle of the data phase.
    cs_begin();
    send_cmd_addr(8'h03, 24'h000010);
    spi_xfer(8'h00, 8, rx);
    check("pre_rst_byte", rx, model_mem[12'h010]);
    spi_xfer(8'h00, 2, rx);
    check("pre_rst_bits", rx, 8'(model_mem[12'h011][7:6]));
    repeat (4) @(negedge clk);
    check("pre_rst_miso", miso, model_mem[12'h011][5]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_miso", miso, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_last_cmd", last_cmd, 8'h00);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    read_bytes(24'h000010, 1);

`ifdef FAST_READ_EN
    cs_begin();
    send_cmd_addr(8'h0B, 24'h000010);
    spi_xfer(8'h00, 8, rx);
    check("dummy_miso", rx, 0);
    exp_q.push_back(model_mem[12'h010]);
    exp_q.push_back(model_mem[12'h011]);
    for (int i = 0; i < 2; i++) begin
      spi_xfer(8'h00, 8, rx);
      pop_check("fast_data", rx);
    end
    cs_end();
    check("fast_last_cmd", last_cmd, 8'h0B);
`else
    cs_begin();
    send_cmd_addr(8'h0B, 24'h000010);
    for (int i = 0; i < 2; i++) begin
      spi_xfer(8'h00, 8, rx);
      check("fast_off_miso", rx, 0);
    end
    cs_end();
    check("fast_off_last_cmd", last_cmd, 8'h0B);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
